// File: rtl/cache_def_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_def (package)
//  Description : Shared cache definitions: accumulate-cache FSM states, the
//                per-line metadata record and a width-parametrised
//                saturating/wrapping adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_def;

    // Widest accumulator and tag that the shared helpers support.
    localparam int c_MAX_DATA_W = 64;
    localparam int c_MAX_TAG_W  = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } accum_state_t;

    // Tag is zero-extended to the package maximum so one record type serves
    // every instance width.
    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [c_MAX_TAG_W-1:0] tag;
    } accum_tag_t;

    // Adds two width-bit operands (held zero-extended in c_MAX_DATA_W bits).
    // With saturate set a carry out of bit width-1 clamps to all-ones,
    // otherwise the carry is dropped.
    function automatic logic [c_MAX_DATA_W-1:0] sat_add(
        input logic [c_MAX_DATA_W-1:0] a,
        input logic [c_MAX_DATA_W-1:0] b,
        input int unsigned             width,
        input logic                    saturate
    );
        logic [c_MAX_DATA_W:0]   sum;
        logic [c_MAX_DATA_W-1:0] mask;
        logic                    carry;
        sum   = {1'b0, a} + {1'b0, b};
        mask  = {c_MAX_DATA_W{1'b1}} >> (c_MAX_DATA_W - width);
        // Operands are below 2^width, so anything left above bit width-1 is
        // exactly the carry.
        carry = (sum >> width) != '0;
        if (saturate && carry) begin
            sat_add = mask;
        end else begin
            sat_add = sum[c_MAX_DATA_W-1:0] & mask;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/accum_line_store.sv
`default_nettype none
// ============================================================================
//  Module      : accum_line_store
//  Description : Direct-mapped line storage for the accumulate cache.
//                Valid/dirty/tag/data arrays with asynchronous read, a single
//                synchronous write port and a bulk valid/dirty clear on rst.
//  Revision    : 1.0 - initial release
// ============================================================================
module accum_line_store
    import cache_def::*;
#(
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = 5,
    parameter int TAG_W     = 8,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output accum_tag_t        rd_meta,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic              wr_dirty,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [DATA_W-1:0]    r_data [NUM_LINES];

    // Status bits: cleared together on reset, any write makes the line valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
            r_dirty[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data payload: never reset, a stale line is masked by valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            r_tag[wr_idx]  <= wr_tag;
            r_data[wr_idx] <= wr_data;
        end
    end

    // Asynchronous read of the addressed line.
    always_comb begin
        rd_meta.valid = r_valid[rd_idx];
        rd_meta.dirty = r_dirty[rd_idx];
        rd_meta.tag   = c_MAX_TAG_W'(r_tag[rd_idx]);
        rd_data       = r_data[rd_idx];
    end

endmodule
`default_nettype wire

// File: rtl/accum_cache_wb.sv
`default_nettype none
// ============================================================================
//  Module      : accum_cache_wb
//  Description : Direct-mapped write-back accumulate cache for per-client
//                running totals. Accumulate or read requests are served from
//                the line store; misses fill from a handshaked backing memory
//                after writing back a dirty victim. Saturating or wrapping
//                sums, saturating hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module accum_cache_wb
    import cache_def::*;
#(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int NUM_LINES = 32,
    parameter int SATURATE  = 1,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_acc,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_misses
);

    localparam int c_IDX_W = $clog2(NUM_LINES);
    localparam int c_TAG_W = ADDR_W - c_IDX_W;

    accum_state_t r_state;
    accum_state_t w_next_state;

    // Latched request
    logic              r_acc;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_first;

    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    accum_tag_t         w_meta;
    logic [DATA_W-1:0]  w_line;
    logic               w_hit;
    logic [DATA_W-1:0]  w_sum;
    logic               w_accept;

    // Line store write port
    logic              w_wr_en;
    logic              w_wr_dirty;
    logic [DATA_W-1:0] w_wr_data;

    assign w_idx    = r_addr[c_IDX_W-1:0];
    assign w_tag    = r_addr[ADDR_W-1:c_IDX_W];
    assign w_hit    = w_meta.valid && (w_meta.tag == c_MAX_TAG_W'(w_tag));
    assign w_sum    = DATA_W'(sat_add(c_MAX_DATA_W'(w_line), c_MAX_DATA_W'(r_data),
                                      DATA_W, SATURATE != 0));
    assign w_accept = req_valid && req_ready;

    accum_line_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (c_IDX_W),
        .TAG_W     (c_TAG_W),
        .DATA_W    (DATA_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (w_idx),
        .rd_meta  (w_meta),
        .rd_data  (w_line),
        .wr_en    (w_wr_en),
        .wr_idx   (w_idx),
        .wr_dirty (w_wr_dirty),
        .wr_tag   (w_tag),
        .wr_data  (w_wr_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = COMPARE;
                end
            end
            COMPARE: begin
                if (w_hit) begin
                    w_next_state = IDLE;
                end else if (w_meta.valid && w_meta.dirty) begin
                    w_next_state = WRITE_BACK;
                end else begin
                    w_next_state = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (mem_resp_valid) begin
                    w_next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_resp_valid) begin
                    w_next_state = COMPARE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State-decoded outputs: handshake, memory request and line-store writes.
    // Memory request fields derive only from the state and latched/stored
    // values, so they hold steady while a response is outstanding.
    always_comb begin
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        w_wr_en       = 1'b0;
        w_wr_dirty    = 1'b0;
        w_wr_data     = w_sum;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
            end
            COMPARE: begin
                if (w_hit && r_acc) begin
                    w_wr_en    = 1'b1;
                    w_wr_dirty = 1'b1;
                    w_wr_data  = w_sum;
                end
            end
            WRITE_BACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {w_meta.tag[c_TAG_W-1:0], w_idx};
                mem_req_data  = w_line;
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_addr;
                if (mem_resp_valid) begin
                    w_wr_en    = 1'b1;
                    w_wr_dirty = 1'b0;
                    w_wr_data  = mem_resp_data;
                end
            end
            default: ;
        endcase
    end

    // Request latch; r_first marks the first compare after an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_first <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= req_acc;
            r_addr  <= req_addr;
            r_data  <= req_data;
            r_first <= 1'b1;
        end else if (r_state == COMPARE) begin
            r_first <= 1'b0;
        end
    end

    // Result pulse on the hitting compare; res_data holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= (r_state == COMPARE) && w_hit;
            if ((r_state == COMPARE) && w_hit) begin
                res_data <= r_acc ? w_sum : w_line;
            end
        end
    end

    // Saturating statistics; the compare after a fill is not a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (r_state == COMPARE) begin
            if (w_hit && r_first && (stat_hits != '1)) begin
                stat_hits <= stat_hits + 1'b1;
            end
            if (!w_hit && (stat_misses != '1)) begin
                stat_misses <= stat_misses + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accum_cache_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum_cache_wb
//  Description : Self-checking bench for accum_cache_wb. Two instances
//                (saturating and wrapping) run in lockstep from one stimulus
//                stream against a per-client running-total reference model
//                and a handshaked backing-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_cache_wb;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int NLINES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_acc = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic mem_resp_valid = 1'b0;
    logic [DATA_W-1:0] resp_s = '0, resp_w = '0;

    logic req_ready_s, req_ready_w, res_valid_s, res_valid_w;
    logic [DATA_W-1:0] res_data_s, res_data_w;
    logic mreq_v_s, mreq_v_w, mreq_we_s, mreq_we_w;
    logic [ADDR_W-1:0] mreq_a_s, mreq_a_w;
    logic [DATA_W-1:0] mreq_d_s, mreq_d_w;
    logic [15:0] hits_s, hits_w, miss_s, miss_w;

    always #5 clk = ~clk;

    accum_cache_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_LINES(NLINES),
                     .SATURATE(1), .STAT_W(16)) dut_s (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
        .req_acc(req_acc), .req_addr(req_addr), .req_data(req_data),
        .res_valid(res_valid_s), .res_data(res_data_s),
        .mem_req_valid(mreq_v_s), .mem_req_we(mreq_we_s), .mem_req_addr(mreq_a_s),
        .mem_req_data(mreq_d_s), .mem_resp_valid(mem_resp_valid), .mem_resp_data(resp_s),
        .stat_hits(hits_s), .stat_misses(miss_s));

    accum_cache_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_LINES(NLINES),
                     .SATURATE(0), .STAT_W(16)) dut_w (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w),
        .req_acc(req_acc), .req_addr(req_addr), .req_data(req_data),
        .res_valid(res_valid_w), .res_data(res_data_w),
        .mem_req_valid(mreq_v_w), .mem_req_we(mreq_we_w), .mem_req_addr(mreq_a_w),
        .mem_req_data(mreq_d_w), .mem_resp_valid(mem_resp_valid), .mem_resp_data(resp_w),
        .stat_hits(hits_w), .stat_misses(miss_w));

    // ---------------- reference model ----------------
    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] ds;
        logic [DATA_W-1:0] dw;
    } mem_exp_t;

    mem_exp_t exp_q[$];
    logic [DATA_W-1:0] mem_s [64];
    logic [DATA_W-1:0] mem_w [64];
    logic [DATA_W-1:0] tot_s [64];
    logic [DATA_W-1:0] tot_w [64];
    bit                res_v [NLINES];
    logic [ADDR_W-1:0] res_a [NLINES];
    bit                res_d [NLINES];
    int unsigned m_hits, m_misses;

    int n_checks = 0;
    int n_fails  = 0;
    int delay_mode = -1;
    bit spurious = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] sadd(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b, input bit sat);
        logic [63:0] s;
        s = 64'(a) + 64'(b);
        if (sat && s > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return s[31:0];
    endfunction

    function automatic void model_reset();
        for (int a = 0; a < 64; a++) begin
            tot_s[a] = mem_s[a];
            tot_w[a] = mem_w[a];
        end
        for (int i = 0; i < NLINES; i++) begin
            res_v[i] = 1'b0;
            res_d[i] = 1'b0;
            res_a[i] = '0;
        end
        m_hits = 0;
        m_misses = 0;
        exp_q.delete();
    endfunction

    // ---------------- backing memory responder ----------------
    bit have_cur = 1'b0;
    mem_exp_t cur;
    int unsigned wait_cnt = 0;

    always @(negedge clk) begin
        mem_resp_valid = 1'b0;
        if (rst) begin
            have_cur = 1'b0;
        end else if (mreq_v_s) begin
            if (!have_cur) begin
                have_cur = 1'b1;
                wait_cnt = (delay_mode < 0) ? $urandom_range(0, 3) : delay_mode;
                check("mem_lockstep", {mreq_v_w, mreq_we_w, mreq_a_w}, {1'b1, mreq_we_s, mreq_a_s});
                if (exp_q.size() == 0) begin
                    check("mem_unexpected_req", 1, 0);
                    cur.we = mreq_we_s; cur.addr = mreq_a_s; cur.ds = mreq_d_s; cur.dw = mreq_d_w;
                end else begin
                    cur = exp_q.pop_front();
                    check("mem_req_we", mreq_we_s, cur.we);
                    check("mem_req_addr", mreq_a_s, cur.addr);
                    if (cur.we) begin
                        check("wb_data_sat", mreq_d_s, cur.ds);
                        check("wb_data_wrap", mreq_d_w, cur.dw);
                    end
                end
            end else begin
                check("mem_req_hold", {mreq_we_s, mreq_a_s, mreq_d_s, mreq_d_w},
                      {cur.we, cur.addr, cur.we ? cur.ds : 32'h0, cur.we ? cur.dw : 32'h0});
                check("ready_while_busy", req_ready_s, 0);
            end
            if (wait_cnt == 0) begin
                mem_resp_valid = 1'b1;
                if (cur.we) begin
                    mem_s[cur.addr] = cur.ds;
                    mem_w[cur.addr] = cur.dw;
                end else begin
                    resp_s = mem_s[cur.addr];
                    resp_w = mem_w[cur.addr];
                end
                have_cur = 1'b0;
            end else begin
                wait_cnt--;
            end
        end else begin
            have_cur = 1'b0;
            if (spurious) begin
                mem_resp_valid = 1'b1;
                resp_s = $urandom;
                resp_w = $urandom;
            end
        end
    end

    // ---------------- request driver ----------------
    task automatic do_req(input logic acc, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        int idx;
        bit hit;
        int n;
        mem_exp_t e;
        logic [DATA_W-1:0] es, ew;
        idx = int'(addr) % NLINES;
        hit = res_v[idx] && (res_a[idx] == addr);
        if (!hit) begin
            if (res_v[idx] && res_d[idx]) begin
                e.we = 1'b1; e.addr = res_a[idx];
                e.ds = tot_s[res_a[idx]]; e.dw = tot_w[res_a[idx]];
                exp_q.push_back(e);
            end
            e.we = 1'b0; e.addr = addr; e.ds = '0; e.dw = '0;
            exp_q.push_back(e);
            res_v[idx] = 1'b1; res_a[idx] = addr; res_d[idx] = 1'b0;
            if (m_misses < 65535) m_misses++;
        end else if (m_hits < 65535) begin
            m_hits++;
        end
        if (acc) begin
            tot_s[addr] = sadd(tot_s[addr], data, 1'b1);
            tot_w[addr] = sadd(tot_w[addr], data, 1'b0);
            res_d[idx] = 1'b1;
        end
        es = tot_s[addr];
        ew = tot_w[addr];

        @(negedge clk);
        req_valid = 1'b1; req_acc = acc; req_addr = addr; req_data = data;
        n = 0;
        while (!req_ready_s && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", req_ready_s, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data = $urandom;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!res_valid_s && n < 200);
        check("res_valid_sat", res_valid_s, 1);
        check("res_valid_wrap", res_valid_w, 1);
        if (hit) check("hit_latency", n, 1);
        check("res_data_sat", res_data_s, es);
        check("res_data_wrap", res_data_w, ew);
        check("ready_at_result", req_ready_s, 1);
        check("hits_sat", hits_s, m_hits);
        check("misses_sat", miss_s, m_misses);
        check("stats_wrap", {hits_w, miss_w}, {16'(m_hits), 16'(m_misses)});
        check("mem_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check("res_pulse_width", res_valid_s, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, req_ready_s, 1);
        check({tag, "_res_valid"}, {res_valid_s, res_valid_w}, 0);
        check({tag, "_mem_req"}, {mreq_v_s, mreq_we_s, mreq_a_s, mreq_d_s}, 0);
        check({tag, "_mem_req_wrap"}, {mreq_v_w, mreq_we_w, mreq_a_w, mreq_d_w}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int quiet;
        mem_exp_t e;
        for (int a = 0; a < 64; a++) begin
            mem_s[a] = $urandom_range(0, 5000);
            mem_w[a] = mem_s[a];
        end
        mem_s[5] = 32'h0;           mem_w[5] = 32'h0;
        mem_s[14] = 32'hFFFF_FFF0;  mem_w[14] = 32'hFFFF_FFF0;
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_res_data", {res_data_s, res_data_w}, 0);
        check("reset_stats", {hits_s, miss_s, hits_w, miss_w}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Cold accumulate, hit accumulate, hit read
        delay_mode = 3;
        do_req(1'b1, 6'h05, 32'd10);
        do_req(1'b1, 6'h05, 32'd7);
        do_req(1'b0, 6'h05, 32'd999);
        check("two_hits", hits_s, 2);

        // Dirty eviction of 0x05 by 0x09
        do_req(1'b1, 6'h09, 32'd1);

        // Saturating vs wrapping sum
        do_req(1'b1, 6'h0E, 32'h20);
        check("sat_clamp", res_data_s, 32'hFFFF_FFFF);
        check("wrap_sum", res_data_w, 32'h0000_0010);

        // Long memory latency: write-back of 0x0E then fill of 0x12
        delay_mode = 20;
        do_req(1'b0, 6'h12, 32'h0);

        // Spurious memory response while idle
        delay_mode = -1;
        @(negedge clk);
        spurious = 1'b1;
        repeat (5) @(negedge clk);
        spurious = 1'b0;
        #1;
        check_idle_outputs("spurious");
        check("spurious_stats", hits_s, m_hits);
        do_req(1'b0, 6'h12, 32'h0);
        do_req(1'b0, 6'h0E, 32'h0);

        // Randomised traffic over a small address set
        for (int i = 0; i < 80; i++) begin
            logic [DATA_W-1:0] d;
            d = ($urandom_range(0, 7) == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 300));
            do_req(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), d);
        end

        // Reset during a fill
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        delay_mode = 2;
        do_req(1'b0, 6'h05, 32'h0);
        delay_mode = 1000;
        e.we = 1'b0; e.addr = 6'h0A; e.ds = '0; e.dw = '0;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_acc = 1'b1; req_addr = 6'h0A; req_data = 32'd5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!mreq_v_s && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("fill_started", mreq_v_s, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_fill_mem_req", {mreq_v_s, mreq_v_w}, 0);
        check("rst_mid_fill_res", res_valid_s, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        quiet = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (res_valid_s || res_valid_w || mreq_v_s) quiet++;
        end
        check("abandoned_quiet", quiet, 0);
        check_idle_outputs("post_reset");
        delay_mode = 1;
        do_req(1'b0, 6'h05, 32'h0);
        check("read_after_reset_misses", miss_s, 1);
        check("read_after_reset_hits", hits_s, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
